// File: rtl/dpkd_pkg.sv
// Shared types and width helpers for the DPKD phase-shift loop controller.
//
// Contents:
//   dpkd_state_e  - controller state encoding (idle / track / hold-off)
//   NetShiftW     - width of the optional signed net-shift statistic
//   filt_width()  - signed random-walk filter width for a given threshold
//   cnt_width()   - unsigned counter width able to hold 0..max_val
package dpkd_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StTrack   = 2'd1,
    StHoldoff = 2'd2
  } dpkd_state_e;

  localparam int unsigned NetShiftW = 16;

  // Two extra bits: one for sign, one so that +filter_n itself is representable.
  function automatic int unsigned filt_width(input int unsigned filter_n);
    return $clog2(filter_n) + 2;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dpkd_rw_filter.sv
// Random-walk (up/down) filter for the DPKD loop.
//
// A signed counter steps +1 on up_i-only, -1 on dn_i-only, and holds on both or
// neither. When the next value would reach +FILTER_N or -FILTER_N the matching
// overflow flag is raised combinationally (so the caller can register its pulse
// on the same edge) and the counter restarts from zero.
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   clear_i    force the counter to zero (dominates hold_i)
//   hold_i     freeze the counter; strobes ignored, no overflow
//   up_i       step toward +FILTER_N
//   dn_i       step toward -FILTER_N
//   ovf_pos_o  next value reaches +FILTER_N
//   ovf_neg_o  next value reaches -FILTER_N
module dpkd_rw_filter
  import dpkd_pkg::*;
#(
  parameter int unsigned FILTER_N = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic hold_i,
  input  logic up_i,
  input  logic dn_i,
  output logic ovf_pos_o,
  output logic ovf_neg_o
);

  localparam int unsigned FiltW = filt_width(FILTER_N);
  localparam logic signed [FiltW-1:0] PosLim = FiltW'(FILTER_N);
  localparam logic signed [FiltW-1:0] NegLim = -PosLim;
  localparam logic signed [FiltW-1:0] One    = FiltW'(1);

  logic signed [FiltW-1:0] cnt_q, cnt_d, stepped;
  logic                    active;

  assign active = !clear_i && !hold_i;

  always_comb begin
    stepped = cnt_q;
    if (up_i && !dn_i) begin
      stepped = cnt_q + One;
    end else if (dn_i && !up_i) begin
      stepped = cnt_q - One;
    end
  end

  assign ovf_pos_o = active && (stepped == PosLim);
  assign ovf_neg_o = active && (stepped == NegLim);

  // Restarting at zero on overflow keeps the count strictly inside
  // (-FILTER_N, +FILTER_N), so no separate saturation clamp is needed.
  always_comb begin
    cnt_d = stepped;
    if (clear_i) begin
      cnt_d = '0;
    end else if (hold_i) begin
      cnt_d = cnt_q;
    end else if (ovf_pos_o || ovf_neg_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dpkd_shift_ctrl.sv
// DPKD phase-shift loop controller.
//
// Filters early/late phase-detector strobes through a random-walk filter and,
// on overflow, issues a single-cycle positive or negative shift pulse to the
// divider, followed by a hold-off during which strobes are ignored. Reports
// lock once LOCK_WINDOW consecutive shift-free tracking cycles have elapsed.
//
// Optional build macro DPKD_SHIFT_STATS_EN adds net_shift_o, a saturating
// signed count of (positive - negative) pulses cleared only by reset.
//
// Ports:
//   clk_i             system clock
//   reset_i           asynchronous active-low reset
//   enable_i          loop enable; low returns the controller to idle
//   early_i           strobe: divider output leads reference
//   late_i            strobe: divider output lags reference
//   positive_shift_o  one-cycle advance pulse to the divider
//   negative_shift_o  one-cycle retard pulse to the divider
//   lock_o            loop locked
//   busy_o            high during hold-off
//   net_shift_o       (DPKD_SHIFT_STATS_EN only) signed net pulse count
module dpkd_shift_ctrl
  import dpkd_pkg::*;
#(
  parameter int unsigned FILTER_N    = 8,
  parameter int unsigned HOLDOFF     = 16,
  parameter int unsigned LOCK_WINDOW = 64
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  input  logic early_i,
  input  logic late_i,
  output logic positive_shift_o,
  output logic negative_shift_o,
  output logic lock_o,
  output logic busy_o
`ifdef DPKD_SHIFT_STATS_EN
  ,
  output logic signed [NetShiftW-1:0] net_shift_o
`endif
);

  localparam int unsigned HoldW  = cnt_width(HOLDOFF);
  localparam int unsigned QuietW = cnt_width(LOCK_WINDOW);
  localparam logic [HoldW-1:0]  HoldLoad = HoldW'(HOLDOFF);
  localparam logic [HoldW-1:0]  HoldOne  = HoldW'(1);
  localparam logic [QuietW-1:0] QuietMax = QuietW'(LOCK_WINDOW);
  localparam logic [QuietW-1:0] QuietOne = QuietW'(1);

  dpkd_state_e       state_q, state_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [QuietW-1:0] quiet_q, quiet_d;
  logic              pos_q, pos_d;
  logic              neg_q, neg_d;
  logic              busy_q, busy_d;
  logic              lock_q, lock_d;

  logic filt_clear, filt_hold, ovf_pos, ovf_neg;

  // The filter only integrates while tracking with the loop enabled.
  assign filt_clear = !enable_i || (state_q == StIdle);
  assign filt_hold  = (state_q == StHoldoff);

  dpkd_rw_filter #(
    .FILTER_N (FILTER_N)
  ) u_filter (
    .clk_i     (clk_i),
    .rst_ni    (reset_i),
    .clear_i   (filt_clear),
    .hold_i    (filt_hold),
    .up_i      (late_i),
    .dn_i      (early_i),
    .ovf_pos_o (ovf_pos),
    .ovf_neg_o (ovf_neg)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    quiet_d = quiet_q;
    pos_d   = 1'b0;
    neg_d   = 1'b0;
    busy_d  = busy_q;

    if (!enable_i) begin
      state_d = StIdle;
      hold_d  = '0;
      quiet_d = '0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          hold_d  = '0;
          quiet_d = '0;
          busy_d  = 1'b0;
          state_d = StTrack;
        end
        StTrack: begin
          if (ovf_pos || ovf_neg) begin
            pos_d   = ovf_pos;
            neg_d   = ovf_neg;
            hold_d  = HoldLoad;
            busy_d  = 1'b1;
            quiet_d = '0;
            state_d = StHoldoff;
          end else if (quiet_q != QuietMax) begin
            quiet_d = quiet_q + QuietOne;
          end
        end
        StHoldoff: begin
          // Quiet counter is frozen here: hold-off neither earns nor costs lock.
          hold_d = hold_q - HoldOne;
          if (hold_q == HoldOne) begin
            busy_d  = 1'b0;
            state_d = StTrack;
          end
        end
        default: begin
          state_d = StIdle;
          hold_d  = '0;
          quiet_d = '0;
          busy_d  = 1'b0;
        end
      endcase
    end

    // Registered copy of (quiet == window), so lock drops on the shift edge.
    lock_d = (quiet_d == QuietMax);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= StIdle;
      hold_q  <= '0;
      quiet_q <= '0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      quiet_q <= quiet_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      lock_q  <= lock_d;
    end
  end

  assign positive_shift_o = pos_q;
  assign negative_shift_o = neg_q;
  assign lock_o           = lock_q;
  assign busy_o           = busy_q;

`ifdef DPKD_SHIFT_STATS_EN
  localparam logic signed [NetShiftW-1:0] NetMax = {1'b0, {(NetShiftW-1){1'b1}}};
  localparam logic signed [NetShiftW-1:0] NetMin = {1'b1, {(NetShiftW-1){1'b0}}};
  localparam logic signed [NetShiftW-1:0] NetOne = NetShiftW'(1);

  logic signed [NetShiftW-1:0] net_q, net_d;

  // Counted on the edge that registers the pulse; enable_i does not clear it.
  always_comb begin
    net_d = net_q;
    if (pos_d && (net_q != NetMax)) begin
      net_d = net_q + NetOne;
    end else if (neg_d && (net_q != NetMin)) begin
      net_d = net_q - NetOne;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      net_q <= '0;
    end else begin
      net_q <= net_d;
    end
  end

  assign net_shift_o = net_q;
`endif

endmodule
